recorrido_max_ctrl: RTL

Sequencer that owns a DEPTH-entry register bank and walks it left-to-right or right-to-left, time-sharing one external Comparador instance to find the maximum value and its index. It drives the comparator's A/B operands each cycle and uses its Z result (Z=1 when B >= A) to decide replacement. The block sits between the load/control logic of the traversal datapath and the shared Comparador, and reports the result with a busy/done handshake.

---
 rtl/recorrido_max_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/recorrido_max_ctrl.sv
// Max/argmax sequencer: walks a DEPTH-entry bank in either direction, time-sharing an
// external Comparador (cmp_z = cmp_b >= cmp_a) and reporting the result with busy/done.
module recorrido_max_ctrl #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int IDXW  = 3
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_addr,
    input  logic [N-1:0]    wr_data,
    input  logic            start,
    input  logic            dir,
    output logic [N-1:0]    cmp_a,
    output logic [N-1:0]    cmp_b,
    input  logic            cmp_z,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    max_val,
    output logic [IDXW-1:0] max_idx
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
    localparam logic [IDXW:0]   DEPTH_W  = (IDXW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [N-1:0]    val;
        logic [IDXW-1:0] idx;
    } best_t;

    state_t                     r_state;
    logic [DEPTH-1:0][N-1:0]    r_bank;
    best_t                      r_best;
    best_t                      r_max;
    logic [IDXW-1:0]            r_ptr;
    logic                       r_dir;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_addr_ok;
    logic                       w_wr_ok;
    logic [DEPTH-1:0]           w_wr_hit;
    logic [N-1:0]               w_cand;
    logic [IDXW-1:0]            w_first_idx;
    logic [IDXW-1:0]            w_first_ptr;
    logic [IDXW-1:0]            w_next_ptr;
    logic                       w_last;
    best_t                      w_scan_best;

    // Bank is writable only in IDLE (when not starting) and in DONE; the scan sees a frozen bank.
    assign w_addr_ok = ({1'b0, wr_addr} < DEPTH_W);
    assign w_wr_ok   = wr_en && w_addr_ok &&
                       (((r_state == S_IDLE) && !start) || (r_state == S_DONE));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_hit
            assign w_wr_hit[gi] = w_wr_ok && (wr_addr == IDXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_bank <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_hit[i]) r_bank[i] <= wr_data;
            end
        end
    end

    assign w_cand      = r_bank[r_ptr];
    assign w_first_idx = dir ? LAST_IDX : '0;
    assign w_first_ptr = dir ? (LAST_IDX - IDXW'(1)) : IDXW'(1);
    assign w_next_ptr  = r_dir ? (r_ptr - IDXW'(1)) : (r_ptr + IDXW'(1));
    assign w_last      = r_dir ? (r_ptr == '0) : (r_ptr == LAST_IDX);
    // Equal candidates replace the best, so ties resolve to the later index in scan order.
    assign w_scan_best = cmp_z ? best_t'{val: w_cand, idx: r_ptr} : r_best;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_best  <= '0;
            r_max   <= '0;
            r_ptr   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dir    <= dir;
                        r_best   <= best_t'{val: r_bank[w_first_idx], idx: w_first_idx};
                        r_ptr    <= w_first_ptr;
                        r_busy   <= 1'b1;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_best <= w_scan_best;
                    if (w_last) begin
                        r_max   <= w_scan_best;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ptr <= w_next_ptr;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmp_a   = (r_state == S_SCAN) ? r_best.val : '0;
    assign cmp_b   = (r_state == S_SCAN) ? w_cand     : '0;
    assign busy    = r_busy;
    assign done    = r_done;
    assign max_val = r_max.val;
    assign max_idx = r_max.idx;

endmodule
